// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_CALC = S_CALC,
        ST_FIX  = S_FIX,
        ST_DONE = S_DONE
    } state_t;

    localparam logic [DIV_WIDTH_DEFAULT-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_if.sv
// Start/busy/done handshake and HI/LO result bus of the divider.
// is_unsigned exists only when DIV_UNSIGNED_EN is defined.
interface div_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);

    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
`ifdef DIV_UNSIGNED_EN
    logic             is_unsigned;
`endif
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] HI;

`ifdef DIV_UNSIGNED_EN
    modport master (
        output start, dividend, divisor, is_unsigned,
        input  busy, done, div_zero, LO, HI
    );
    modport slave (
        input  start, dividend, divisor, is_unsigned,
        output busy, done, div_zero, LO, HI
    );
`else
    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, LO, HI
    );
    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, LO, HI
    );
`endif

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] r_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] diff;
    logic             ge;

    // The shifted remainder needs WIDTH+1 bits; when it is >= M the
    // difference is < M, so its low WIDTH bits are the whole result.
    always_comb begin
        r_sh   = {r, q[WIDTH-1]};
        ge     = r_sh >= {1'b0, m};
        diff   = r_sh[WIDTH-1:0] - m;
        r_next = ge ? diff : r_sh[WIDTH-1:0];
        q_next = {q[WIDTH-2:0], ge};
    end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed restoring divider: quotient to LO, remainder to HI.
// Define DIV_UNSIGNED_EN to add the is_unsigned (DIVU) option.
module div_seq
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input logic  clk,
    input logic  reset,
    div_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] m;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic [WIDTH-1:0] r_step;
    logic [WIDTH-1:0] q_step;
    logic             uns;
    logic             a_neg;
    logic             b_neg;
    logic             zero;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef DIV_UNSIGNED_EN
    assign uns = bus.is_unsigned;
`else
    assign uns = 1'b0;
`endif

    // Magnitudes are held unsigned, so -2^(WIDTH-1) maps exactly to 2^(WIDTH-1).
    assign a_neg = !uns && bus.dividend[WIDTH-1];
    assign b_neg = !uns && bus.divisor[WIDTH-1];
    assign a_mag = a_neg ? -bus.dividend : bus.dividend;
    assign b_mag = b_neg ? -bus.divisor : bus.divisor;
    assign zero  = bus.divisor == '0;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .r      (r),
        .q      (q),
        .m      (m),
        .r_next (r_step),
        .q_next (q_step)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = zero ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt == CW'(1)) begin
                    state_next = ST_FIX;
                end
            end
            ST_FIX:  state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.busy = (state == ST_CALC) || (state == ST_FIX);
    assign bus.done = state == ST_DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            q            <= '0;
            r            <= '0;
            m            <= '0;
            cnt          <= '0;
            neg_q        <= 1'b0;
            neg_r        <= 1'b0;
            bus.div_zero <= 1'b0;
            bus.LO       <= '0;
            bus.HI       <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        q            <= a_mag;
                        m            <= b_mag;
                        r            <= '0;
                        cnt          <= CW'(WIDTH);
                        neg_q        <= a_neg ^ b_neg;
                        neg_r        <= a_neg;
                        bus.div_zero <= zero;
                        if (zero) begin
                            bus.LO <= {WIDTH{DIV_ZERO_QUOT[0]}};
                            bus.HI <= bus.dividend;
                        end
                    end
                end
                ST_CALC: begin
                    r   <= r_step;
                    q   <= q_step;
                    cnt <= cnt - CW'(1);
                end
                ST_FIX: begin
                    bus.LO <= neg_q ? -q : q;
                    bus.HI <= neg_r ? -r : r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq (table vectors plus corner sequences).
`timescale 1ns/1ps
module tb_div_seq;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        uns;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        dz;
        int          cyc;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t vecs[$];

    div_if #(.WIDTH(32)) bus();

    div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic uns);
        bus.dividend = a;
        bus.divisor  = b;
`ifdef DIV_UNSIGNED_EN
        bus.is_unsigned = uns;
`else
        if (uns) $display("note: unsigned vector in signed-only build");
`endif
    endtask

    // Issue one op, wait for done, compare latency and results.
    task automatic run_op(input string name, input vec_t v);
        int lat;
        @(negedge clk);
        drive(v.a, v.b, v.uns);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({name, " busy"}, {31'd0, bus.busy}, {31'd0, v.b != 0});
        lat = 0;
        while (bus.done !== 1'b1 && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 100) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no done, expected done", name);
        end else begin
            check({name, " cycle"}, lat + 1, v.cyc);
            check({name, " lo"}, bus.LO, v.lo);
            check({name, " hi"}, bus.HI, v.hi);
            check({name, " dz"}, {31'd0, bus.div_zero}, {31'd0, v.dz});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        bool_init();
    end

    task automatic bool_init();
        bit seen;
        errors = 0;
        checks = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        drive(32'd0, 32'd0, 1'b0);

        vecs.push_back('{32'd7, 32'd2, 1'b0, 32'd3, 32'd1, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34});
        vecs.push_back('{32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h80000000, 32'd0, 1'b0, 34});
        vecs.push_back('{32'd100, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h64, 1'b1, 1});
        vecs.push_back('{32'd20, 32'hFFFFFFFD, 1'b0, 32'hFFFFFFFA, 32'd2, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFEC, 32'hFFFFFFFD, 1'b0, 32'd6, 32'hFFFFFFFE, 1'b0, 34});
        vecs.push_back('{32'd5, 32'd7, 1'b0, 32'd0, 32'd5, 1'b0, 34});
        vecs.push_back('{32'h7FFFFFFF, 32'd1, 1'b0, 32'h7FFFFFFF, 32'd0, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFFF, 32'd2, 1'b0, 32'd0, 32'hFFFFFFFF, 1'b0, 34});
        vecs.push_back('{32'd0, 32'd5, 1'b0, 32'd0, 32'd0, 1'b0, 34});
        vecs.push_back('{32'h80000000, 32'd2, 1'b0, 32'hC0000000, 32'd0, 1'b0, 34});
        vecs.push_back('{32'h80000000, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1});
        vecs.push_back('{32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, 34});
`ifdef DIV_UNSIGNED_EN
        vecs.push_back('{32'hFFFFFFFF, 32'd2, 1'b1, 32'h7FFFFFFF, 32'd1, 1'b0, 34});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 32'd1, 32'd1, 1'b0, 34});
        vecs.push_back('{32'h80000000, 32'd0, 1'b1, 32'hFFFFFFFF, 32'h80000000, 1'b1, 1});
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst dz", {31'd0, bus.div_zero}, 32'd0);
        check("rst lo", bus.LO, 32'd0);
        check("rst hi", bus.HI, 32'd0);

        foreach (vecs[i]) begin
            run_op($sformatf("v%0d", i), vecs[i]);
        end

        // Divide by zero, then a valid op must clear div_zero on accept.
        run_op("dz1", '{32'd100, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h64, 1'b1, 1});
        @(negedge clk);
        drive(32'd7, 32'd2, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("dz clear", {31'd0, bus.div_zero}, 32'd0);
        check("dz busy", {31'd0, bus.busy}, 32'd1);
        repeat (40) @(posedge clk);
        #1;

        // Start while busy and operand changes are ignored.
        @(negedge clk);
        drive(32'd50, 32'd7, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        drive(32'd9, 32'd3, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ign busy", {31'd0, bus.busy}, 32'd1);
        seen = 1'b0;
        for (int k = 0; k < 60 && !seen; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                seen = 1'b1;
                check("ign cycle", k + 12, 34);
                check("ign lo", bus.LO, 32'd7);
                check("ign hi", bus.HI, 32'd1);
            end
        end
        check("ign done", {31'd0, seen}, 32'd1);
        repeat (3) @(posedge clk);

        // Reset mid-operation aborts; no done afterwards.
        @(negedge clk);
        drive(32'd50, 32'd7, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        drive(32'd9, 32'd3, 1'b0);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid busy", {31'd0, bus.busy}, 32'd0);
        check("mid done", {31'd0, bus.done}, 32'd0);
        check("mid lo", bus.LO, 32'd0);
        check("mid hi", bus.HI, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) seen = 1'b1;
        end
        check("mid quiet", {31'd0, seen}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

endmodule
